// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, diff = a - b - bin, one bit per clock LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic             br, br_next, d;
  logic [CW-1:0]    cnt;
  logic             load, last;

  // Full-subtractor slice on the current LSBs; the new bit enters the result MSB
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
    sr_next = sr >> 1;
    sr_next[WIDTH-1] = d;
    last    = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, handshake outputs and operand-load strobe
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish result on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_next;
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= sr_next;
        bout <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8, 3 and 1
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8, s3, s1;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic       a1, b1;
  logic       bi8, bi3, bi1;
  logic       busy8, done8, bout8, busy3, done3, bout3, busy1, done1, bout1;
  logic [7:0] diff8;
  logic [2:0] diff3;
  logic       diff1;

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3), .bin(bi3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result taken modulo 2^w, borrow = negative result
  function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bin);
    int r;
    logic [8:0] res;
    r = a - b - bin;
    res = '0;
    res[8] = (r < 0);
    res[7:0] = 8'(r & ((1 << w) - 1));
    return res;
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b, input logic bi);
    case (w)
      8: begin s8 = st; a8 = a; b8 = b; bi8 = bi; end
      3: begin s3 = st; a3 = a[2:0]; b3 = b[2:0]; bi3 = bi; end
      default: begin s1 = st; a1 = a[0]; b1 = b[0]; bi1 = bi; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 3) ? done3 : done1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 3) ? busy3 : busy1;
  endfunction
  function automatic logic get_bout(input int w);
    return (w == 8) ? bout8 : (w == 3) ? bout3 : bout1;
  endfunction
  function automatic logic [7:0] get_diff(input int w);
    return (w == 8) ? diff8 : (w == 3) ? {5'b0, diff3} : {7'b0, diff1};
  endfunction

  // One start pulse, then wait (bounded) for done; reports cycle of done, busy cycles and result stability
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo, output int cyc, output int bc,
                        output logic stable);
    logic [7:0] prev;
    @(negedge clk);
    prev = get_diff(w);
    drive(w, 1'b1, a, b, bi);
    @(negedge clk);
    drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc = 1;
    bc = 0;
    stable = 1'b1;
    while (get_done(w) !== 1'b1 && cyc < 40) begin
      if (get_busy(w) === 1'b1) bc++;
      if (get_diff(w) !== prev) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", get_done(w), 1);
    d = get_diff(w);
    bo = get_bout(w);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [7:0] d;
    logic       bo;
    logic [8:0] expv;
    int         cyc, bc, cnt;
    logic       stable;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bout", bout8, 0);
    rst_n = 1'b1;

    // Directed vectors, WIDTH=8
    for (int i = 0; i < 4; i++) begin
      run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, cyc, bc, stable);
      check($sformatf("vec%0d_diff", i), d, vecs[i].exp_diff);
      check($sformatf("vec%0d_bout", i), bo, vecs[i].exp_bout);
      check($sformatf("vec%0d_latency", i), cyc, 9);
      check($sformatf("vec%0d_busy_cycles", i), bc, 8);
      check($sformatf("vec%0d_stable", i), stable, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done8, 0);
    end

    // Random operands against the arithmetic model, WIDTH=8
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rbi;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      run_op(8, ra, rb, rbi, d, bo, cyc, bc, stable);
      expv = ref_sub(8, int'(ra), int'(rb), int'(rbi));
      check($sformatf("rnd%0d_result", i), {bo, d}, expv);
      check($sformatf("rnd%0d_stable", i), stable, 1);
    end

    // Start held through RUN, operands changed after capture, back-to-back accept in DONE
    @(negedge clk);
    drive(8, 1'b1, 8'h20, 8'h05, 1'b0);
    @(negedge clk);
    drive(8, 1'b1, 8'h77, 8'h11, 1'b1);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_first_latency", cyc, 9);
    check("b2b_first_diff", diff8, 8'h1B);
    check("b2b_first_bout", bout8, 0);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    check("b2b_second_busy", busy8, 1);
    cyc = 1;
    stable = 1'b1;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (diff8 !== 8'h1B) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b_hold_first", stable, 1);
    check("b2b_second_gap", cyc, 9);
    check("b2b_second_diff", diff8, 8'h65);
    check("b2b_second_bout", bout8, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    drive(8, 1'b1, 8'h44, 8'h22, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("midrun_busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy8, 0);
    check("midrun_rst_done", done8, 0);
    check("midrun_rst_diff", diff8, 0);
    check("midrun_rst_bout", bout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) cnt++;
    end
    check("midrun_no_done", cnt, 0);
    run_op(8, 8'h03, 8'h05, 1'b0, d, bo, cyc, bc, stable);
    check("post_rst_diff", d, 8'hFE);
    check("post_rst_bout", bo, 1);

    // Exhaustive WIDTH=3
    for (int i = 0; i < 128; i++) begin
      logic [2:0] ea, eb;
      logic       ebi;
      ea = 3'(i >> 4);
      eb = 3'(i >> 1);
      ebi = 1'(i);
      run_op(3, {5'b0, ea}, {5'b0, eb}, ebi, d, bo, cyc, bc, stable);
      expv = ref_sub(3, int'(ea), int'(eb), int'(ebi));
      check($sformatf("w3_%0d_result", i), {bo, d[2:0]}, {expv[8], expv[2:0]});
      check($sformatf("w3_%0d_stable", i), stable, 1);
    end
    check("w3_latency", cyc, 4);

    // WIDTH=1
    run_op(1, 8'h00, 8'h01, 1'b0, d, bo, cyc, bc, stable);
    check("w1_latency", cyc, 2);
    check("w1_busy_cycles", bc, 1);
    check("w1_diff", d, 8'h01);
    check("w1_bout", bo, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
